// File: rtl/switch_debounce_pkg.sv
// rtl/switch_debounce_pkg.sv - shared state encoding and board timing constants for switch_debounce
package switch_debounce_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } db_state_e;

  // Default timing for the 50 MHz board clock
  localparam int DB_20MS = 1_000_000;
  localparam int LONG_1S = 50_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous pin inputs
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the pin through two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Stage registers reset to the pin's idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - push-switch debounce with press/release strobes; SWDEB_LONG_PRESS_EN adds long_pulse
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int DB_CYCLES     = DB_20MS,
  parameter int LONG_CYCLES   = LONG_1S,
  parameter bit SW_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_in,
  output logic       sw_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_cnt
);

  localparam int CNT_W = $clog2(max_int(DB_CYCLES, LONG_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic PIN_IDLE = SW_ACTIVE_LOW;

  logic pin_sync;
  logic raw;

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             sw_level_q, sw_level_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic [7:0]       press_cnt_q, press_cnt_d;

  sync_2ff #(
    .RESET_VAL(PIN_IDLE)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sw_in),
    .q    (pin_sync)
  );

  // raw is 1 whenever the synchronised pin reads "pressed"
  assign raw = pin_sync ^ SW_ACTIVE_LOW;

  // Next state, debounce window counter and registered output values
  always_comb begin
    state_d         = state_q;
    db_cnt_d        = db_cnt_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    press_cnt_d     = press_cnt_q;
    unique case (state_q)
      ST_RELEASED: begin
        if (raw) state_d = ST_PRESS_CHK;
      end
      ST_PRESS_CHK: begin
        if (!raw) begin
          state_d = ST_RELEASED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d       = ST_PRESSED;
          press_pulse_d = 1'b1;
          press_cnt_d   = press_cnt_q + 8'd1;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!raw) state_d = ST_RELEASE_CHK;
      end
      ST_RELEASE_CHK: begin
        if (raw) begin
          state_d = ST_PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d         = ST_RELEASED;
          release_pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_RELEASED;
    endcase
    // Every state entry opens a fresh check window
    if (state_d != state_q) db_cnt_d = '0;
    sw_level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_CHK);
  end

  // FSM, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_RELEASED;
      db_cnt_q        <= '0;
      sw_level_q      <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      press_cnt_q     <= 8'd0;
    end else begin
      state_q         <= state_d;
      db_cnt_q        <= db_cnt_d;
      sw_level_q      <= sw_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      press_cnt_q     <= press_cnt_d;
    end
  end

  assign sw_level      = sw_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign press_cnt     = press_cnt_q;

`ifdef SWDEB_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_DONE = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             long_pulse_q, long_pulse_d;

  // Hold timer: restarts on an accepted press, ignores release bounce, parks past the strobe point
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    long_pulse_d = 1'b0;
    if (state_q == ST_PRESS_CHK && state_d == ST_PRESSED) begin
      hold_cnt_d = '0;
    end else if (state_q == ST_PRESSED || state_q == ST_RELEASE_CHK) begin
      if (hold_cnt_q == LONG_LAST) long_pulse_d = 1'b1;
      if (hold_cnt_q != LONG_DONE) hold_cnt_d = hold_cnt_q + CNT_ONE;
    end else begin
      hold_cnt_d = '0;
    end
  end

  // Hold timer and long-press strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q   <= '0;
      long_pulse_q <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      long_pulse_q <= long_pulse_d;
    end
  end

  assign long_pulse = long_pulse_q;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - directed self-checking bench for switch_debounce
module tb_switch_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_in = 1'b1;
  logic       sw_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_cnt;

  int n_chk = 0;
  int n_err = 0;

  // monitor state (written only by the monitor)
  int cyc = 0;
  int press_n = 0, rel_n = 0, long_n = 0;
  int press_edge = 0, rel_edge = 0, long_edge = 0;
  int wide_n = 0, both_n = 0;
  logic prev_p = 1'b0, prev_r = 1'b0, prev_l = 1'b0;

  // stimulus state (written only by the main initial block)
  int drive_edge = 0;
  int p0, r0, l0;

  switch_debounce #(
    .DB_CYCLES    (8),
    .LONG_CYCLES  (32),
    .SW_ACTIVE_LOW(1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_in        (sw_in),
    .sw_level     (sw_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_cnt    (press_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (press_pulse) begin press_n <= press_n + 1; press_edge <= cyc; end
    if (release_pulse) begin rel_n <= rel_n + 1; rel_edge <= cyc; end
    if (long_pulse) begin long_n <= long_n + 1; long_edge <= cyc; end
    if ((press_pulse && prev_p) || (release_pulse && prev_r) || (long_pulse && prev_l))
      wide_n <= wide_n + 1;
    if (press_pulse && release_pulse) both_n <= both_n + 1;
    prev_p <= press_pulse;
    prev_r <= release_pulse;
    prev_l <= long_pulse;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // called at a negedge: pin takes lvl before edge drive_edge and is held n clocks
  task automatic drive(input logic lvl, input int n);
    sw_in = lvl;
    drive_edge = cyc + 1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    p0 = press_n;
    r0 = rel_n;
    l0 = long_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_edge;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sw_level", sw_level, 0);
    check("rst_press_pulse", press_pulse, 0);
    check("rst_release_pulse", release_pulse, 0);
    check("rst_long_pulse", long_pulse, 0);
    check("rst_press_cnt", press_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;

    // 1 clean press then clean release
    snap();
    drive(1'b0, 40);
    n_edge = drive_edge;
    check("t1_press_count", press_n - p0, 1);
    check("t1_press_latency", press_edge - n_edge, 10);
    check("t1_sw_level", sw_level, 1);
    check("t1_press_cnt", press_cnt, 1);
    check("t1_no_release", rel_n - r0, 0);
    snap();
    drive(1'b1, 40);
    n_edge = drive_edge;
    check("t1_release_count", rel_n - r0, 1);
    check("t1_release_latency", rel_edge - n_edge, 10);
    check("t1_sw_level_rel", sw_level, 0);

    // 2 bounce on press
    snap();
    drive(1'b0, 5);
    drive(1'b1, 2);
    check("t2_level_mid_bounce", sw_level, 0);
    drive(1'b0, 20);
    n_edge = drive_edge;
    check("t2_press_count", press_n - p0, 1);
    check("t2_press_latency", press_edge - n_edge, 10);
    check("t2_press_cnt", press_cnt, 2);
    drive(1'b1, 20);

    // 3 glitch shorter than the window
    snap();
    drive(1'b0, 7);
    drive(1'b1, 20);
    check("t3_press_count", press_n - p0, 0);
    check("t3_release_count", rel_n - r0, 0);
    check("t3_sw_level", sw_level, 0);
    check("t3_press_cnt", press_cnt, 2);

    // 4 release with bounce
    drive(1'b0, 20);
    check("t4_pressed", sw_level, 1);
    snap();
    drive(1'b1, 3);
    drive(1'b0, 2);
    check("t4_level_mid_bounce", sw_level, 1);
    drive(1'b1, 20);
    n_edge = drive_edge;
    check("t4_release_count", rel_n - r0, 1);
    check("t4_release_latency", rel_edge - n_edge, 10);
    check("t4_no_press", press_n - p0, 0);
    check("t4_press_cnt", press_cnt, 3);
    check("t4_sw_level", sw_level, 0);

    // 5 long press
    snap();
    drive(1'b0, 60);
    check("t5_press_count", press_n - p0, 1);
`ifdef SWDEB_LONG_PRESS_EN
    check("t5_long_count", long_n - l0, 1);
    check("t5_long_delay", long_edge - press_edge, 32);
`else
    check("t5_long_count", long_n - l0, 0);
`endif
    drive(1'b1, 20);
    check("t5_press_cnt", press_cnt, 4);

    // 6 wrap of press_cnt
    snap();
    for (int i = 0; i < 251; i++) begin
      drive(1'b0, 12);
      drive(1'b1, 12);
    end
    check("t6_press_cnt_255", press_cnt, 255);
    drive(1'b0, 12);
    drive(1'b1, 12);
    check("t6_press_cnt_wrap", press_cnt, 0);
    check("t6_press_count", press_n - p0, 252);
    check("t6_release_count", rel_n - r0, 252);

    // 6 reset in the middle of PRESS_CHK
    drive(1'b0, 5);
    rst_n = 1'b0;
    sw_in = 1'b1;
    #1;
    check("t6_rst_sw_level", sw_level, 0);
    check("t6_rst_press_pulse", press_pulse, 0);
    check("t6_rst_press_cnt", press_cnt, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    snap();
    repeat (20) @(negedge clk);
    #1;
    check("t6_no_strobe_after_rst", press_n - p0, 0);
    check("t6_no_release_after_rst", rel_n - r0, 0);

    // switch held across reset release
    sw_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    snap();
    n_edge = cyc + 1;
    repeat (20) @(negedge clk);
    #1;
    check("t6_held_press_count", press_n - p0, 1);
    check("t6_held_press_latency", press_edge - n_edge, 10);
    check("t6_held_press_cnt", press_cnt, 1);

    check("pulse_width_one_clk", wide_n, 0);
    check("press_release_overlap", both_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
